// File: rtl/sap_out_uart.sv
// SAP-1 output stage: captured bus bytes are queued in a small FIFO and
// shipped out as 8N1 UART frames on a single tx pin.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | line high; pops the FIFO head into the shift register when count>0
// START | start bit (tx=0) for CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (tx=1) for CLKS_PER_BIT cycles, then back to IDLE
module sap_out_uart #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       bus_in,
    input  logic             capture,
    input  logic             clear_ovf,
    output logic             tx,
    output logic             busy,
    output logic             fifo_full,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow
);

    localparam int               PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [15:0]        baud_q, baud_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         mem_q [FIFO_DEPTH];

    logic pop;
    logic push;
    logic drop;
    logic baud_wrap;

    // A pop frees a slot on the same edge, so a full FIFO still accepts a push then.
    assign pop       = (state_q == IDLE) && (count_q != '0);
    assign push      = capture && ((count_q != DEPTH_C) || pop);
    assign drop      = capture && !push;
    assign baud_wrap = (baud_q == BAUD_LAST);

    always_comb begin
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = START;
                    baud_d  = '0;
                    shift_d = mem_q[rd_ptr_q];
                end
            end
            START: begin
                if (baud_wrap) begin
                    state_d   = DATA;
                    baud_d    = '0;
                    bit_idx_d = '0;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    state_d = IDLE;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // tx is derived from the next state so the registered pin lines up with the state.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_sap_out_uart.sv
// Directed bench for sap_out_uart with CLKS_PER_BIT=4, FIFO_DEPTH=4; a line
// monitor decodes every frame so byte order and frame spacing can be checked.
module tb_sap_out_uart;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] bus_in = 8'h00;
    logic       capture = 1'b0;
    logic       clear_ovf = 1'b0;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic [2:0] fifo_count;
    logic       overflow;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [7:0] rxq[$];
    int         rxt[$];
    logic [7:0] exp_q[$];

    sap_out_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .bus_in(bus_in), .capture(capture),
        .clear_ovf(clear_ovf), .tx(tx), .busy(busy), .fifo_full(fifo_full),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (busy && n < max_cyc) begin
            tick();
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic check_frames(input bit gap_check);
        chk("n_frames", rxq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rxq.size()) chk("frame_byte", rxq[i], exp_q[i]);
            if (gap_check && i > 0 && i < rxq.size())
                chk("frame_gap", rxt[i] - rxt[i-1], 10 * CPB + 1);
        end
        rxq.delete();
        rxt.delete();
        exp_q.delete();
    endtask

    initial begin : line_monitor
        logic [7:0] b;
        int t;
        forever begin
            tick();
            if (rst && tx === 1'b0) begin
                t = cyc;
                repeat (CPB / 2) tick();
                chk("start_bit", tx, 0);
                for (int j = 0; j < 8; j++) begin
                    repeat (CPB) tick();
                    b[j] = tx;
                end
                repeat (CPB) tick();
                chk("stop_bit", tx, 1);
                rxq.push_back(b);
                rxt.push_back(t);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [7:0] v;
        int idx;

        // Reset and idle line
        repeat (3) tick();
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("idle_line", {tx, busy, fifo_full, overflow, fifo_count}, 7'b1000_000);
        end

        // Single byte, cycle-exact line check
        v = 8'hA5;
        bus_in = v; capture = 1'b1;
        tick();
        capture = 1'b0;
        chk("a5_count", fifo_count, 1);
        chk("a5_tx_pre", tx, 1);
        for (int k = 1; k <= 40; k++) begin
            tick();
            idx = (k - 1) / CPB;
            if (idx == 0)      chk("a5_start", tx, 0);
            else if (idx == 9) chk("a5_stop", tx, 1);
            else               chk("a5_data", tx, v[idx-1]);
            chk("a5_busy", busy, 1);
        end
        tick();
        chk("a5_busy_drop", busy, 0);
        chk("a5_tx_idle", tx, 1);
        exp_q.push_back(8'hA5);
        check_frames(1'b0);

        // Six captures back to back: one pop frees a slot, the sixth drops
        for (int i = 1; i <= 6; i++) begin
            bus_in = 8'(i); capture = 1'b1;
            tick();
        end
        capture = 1'b0;
        chk("six_ovf", overflow, 1);
        chk("six_count", fifo_count, 4);
        chk("six_full", fifo_full, 1);
        wait_idle(400);
        chk("six_ovf_sticky", overflow, 1);
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        check_frames(1'b1);

        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("ovf_clear_nodrop", overflow, 0);

        // Drop coinciding with clear, then push on the IDLE pop edge
        for (int i = 0; i < 6; i++) begin
            bus_in = 8'h10 + 8'(i); capture = 1'b1; clear_ovf = (i == 5);
            tick();
        end
        capture = 1'b0; clear_ovf = 1'b0;
        chk("ovf_set_wins", overflow, 1);
        chk("fill_count", fifo_count, 4);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("ovf_clear_mid", overflow, 0);
        repeat (35) tick();
        chk("popedge_pre_count", fifo_count, 4);
        chk("popedge_pre_tx", tx, 1);
        bus_in = 8'h99; capture = 1'b1;
        tick();
        capture = 1'b0;
        chk("popedge_count", fifo_count, 4);
        chk("popedge_full", fifo_full, 1);
        chk("popedge_ovf", overflow, 0);
        chk("popedge_tx", tx, 0);
        wait_idle(400);
        for (int i = 0; i < 5; i++) exp_q.push_back(8'h10 + 8'(i));
        exp_q.push_back(8'h99);
        check_frames(1'b1);

        // Asynchronous reset in DATA bit 3
        bus_in = 8'h00; capture = 1'b1;
        tick();
        bus_in = 8'h55;
        tick();
        capture = 1'b0;
        repeat (17) tick();
        chk("pre_rst_tx", tx, 0);
        chk("pre_rst_count", fifo_count, 1);
        rst = 1'b0;
        #1;
        chk("arst_tx", tx, 1);
        chk("arst_count", fifo_count, 0);
        chk("arst_busy", busy, 0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (50) tick();
        chk("post_rst_busy", busy, 0);
        rxq.delete();
        rxt.delete();
        bus_in = 8'h3C; capture = 1'b1;
        tick();
        capture = 1'b0;
        wait_idle(200);
        exp_q.push_back(8'h3C);
        check_frames(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
